table_writer: RTL and testbench

//  Aho-Corasick goto-table builder: takes keyword characters over a valid/ready stream, walks the goto trie it has

---
 rtl/table_writer.sv | 207 ++++++++++++++++++++
 tb/tb_table_writer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/table_writer.sv
// rtl/table_writer.sv - Aho-Corasick goto-table builder: walks the trie per character, appends unseen transitions
// Optional feature macro: TABLE_WRITER_OUTPUT_EN (per-keyword out_wr_en / out_wr_state / out_wr_id strobe)
module table_writer #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int SW    = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          char_valid,
  output logic          char_ready,
  input  logic [CW-1:0] char,
  input  logic          char_last,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [SW-1:0] wr_cur_state,
  output logic [CW-1:0] wr_chara,
  output logic [SW-1:0] wr_next_state,
  output logic [AW:0]   entry_count,
  output logic [SW-1:0] state_count,
  output logic          err
`ifdef TABLE_WRITER_OUTPUT_EN
  ,
  output logic          out_wr_en,
  output logic [SW-1:0] out_wr_state,
  output logic [SW-1:0] out_wr_id
`endif
);

  typedef enum logic [1:0] {IDLE, SEARCH, APPEND, SKIP} state_t;

  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   IDX_ONE   = (AW+1)'(1);
  localparam logic [SW-1:0] SW_ONE    = SW'(1);
  localparam logic [SW-1:0] STATE_MAX = '1;

  state_t        state;
  logic [SW-1:0] cur;
  logic [CW-1:0] ch;
  logic          last;
  logic [AW:0]   idx;
  logic          wr_en_q;

  logic [SW-1:0] sh_cur   [DEPTH];
  logic [CW-1:0] sh_chara [DEPTH];
  logic [SW-1:0] sh_next  [DEPTH];

`ifdef TABLE_WRITER_OUTPUT_EN
  logic [SW-1:0] kw_cnt;
`endif

  logic [AW-1:0] rd_addr;
  logic          in_range;
  logic          hit;
  logic          at_end;
  logic          full;
  logic          accept;
  logic [SW-1:0] new_state;

  assign rd_addr   = idx[AW-1:0];
  assign in_range  = idx < entry_count;
  // in_range gates the compare so never-written shadow slots cannot produce a hit
  assign hit       = in_range && (sh_cur[rd_addr] == cur) && (sh_chara[rd_addr] == ch);
  assign at_end    = (idx == entry_count);
  assign full      = (entry_count == DEPTH_C) || (state_count == STATE_MAX);
  assign accept    = char_valid & char_ready;
  assign new_state = state_count + SW_ONE;

  // A clear arriving in the APPEND cycle must suppress the strobe already registered for it
  assign wr_en = wr_en_q & ~clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cur           <= '0;
      ch            <= '0;
      last          <= 1'b0;
      idx           <= '0;
      char_ready    <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr       <= '0;
      wr_cur_state  <= '0;
      wr_chara      <= '0;
      wr_next_state <= '0;
      entry_count   <= '0;
      state_count   <= '0;
      err           <= 1'b0;
`ifdef TABLE_WRITER_OUTPUT_EN
      out_wr_en     <= 1'b0;
      out_wr_state  <= '0;
      out_wr_id     <= '0;
      kw_cnt        <= '0;
`endif
    end else if (clear) begin
      state         <= IDLE;
      cur           <= '0;
      ch            <= '0;
      last          <= 1'b0;
      idx           <= '0;
      char_ready    <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr       <= '0;
      wr_cur_state  <= '0;
      wr_chara      <= '0;
      wr_next_state <= '0;
      entry_count   <= '0;
      state_count   <= '0;
      err           <= 1'b0;
`ifdef TABLE_WRITER_OUTPUT_EN
      out_wr_en     <= 1'b0;
      out_wr_state  <= '0;
      out_wr_id     <= '0;
      kw_cnt        <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
`ifdef TABLE_WRITER_OUTPUT_EN
      out_wr_en <= 1'b0;
`endif
      case (state)
        IDLE: begin
          char_ready <= 1'b1;
          if (accept) begin
            ch         <= char;
            last       <= char_last;
            idx        <= '0;
            char_ready <= 1'b0;
            state      <= SEARCH;
          end
        end
        SEARCH: begin
          if (hit) begin
            state      <= IDLE;
            char_ready <= 1'b1;
            if (last) begin
              cur <= '0;
`ifdef TABLE_WRITER_OUTPUT_EN
              out_wr_en    <= 1'b1;
              out_wr_state <= sh_next[rd_addr];
              out_wr_id    <= kw_cnt;
              if (kw_cnt != STATE_MAX) kw_cnt <= kw_cnt + SW_ONE;
`endif
            end else begin
              cur <= sh_next[rd_addr];
            end
          end else if (at_end) begin
            if (full) begin
              err        <= 1'b1;
              char_ready <= 1'b1;
              if (last) begin
                cur   <= '0;
                state <= IDLE;
              end else begin
                state <= SKIP;
              end
            end else begin
              wr_en_q       <= 1'b1;
              wr_addr       <= entry_count[AW-1:0];
              wr_cur_state  <= cur;
              wr_chara      <= ch;
              wr_next_state <= new_state;
              state         <= APPEND;
            end
          end else begin
            idx <= idx + IDX_ONE;
          end
        end
        APPEND: begin
          entry_count <= entry_count + IDX_ONE;
          state_count <= new_state;
          state       <= IDLE;
          char_ready  <= 1'b1;
          if (last) begin
            cur <= '0;
`ifdef TABLE_WRITER_OUTPUT_EN
            out_wr_en    <= 1'b1;
            out_wr_state <= new_state;
            out_wr_id    <= kw_cnt;
            if (kw_cnt != STATE_MAX) kw_cnt <= kw_cnt + SW_ONE;
`endif
          end else begin
            cur <= new_state;
          end
        end
        SKIP: begin
          // Rest of an overflowed keyword: ready stays high, characters are dropped
          if (accept && char_last) begin
            cur   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !clear && state == APPEND) begin
      sh_cur[wr_addr]   <= wr_cur_state;
      sh_chara[wr_addr] <= wr_chara;
      sh_next[wr_addr]  <= wr_next_state;
    end
  end

endmodule

// File: tb/tb_table_writer.sv
// tb/tb_table_writer.sv - self-checking bench for table_writer against a trie/list reference model
module tb_table_writer;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int SW    = 8;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          char_valid = 1'b0;
  logic          char_ready;
  logic [CW-1:0] char_in = '0;
  logic          char_last = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [SW-1:0] wr_cur_state;
  logic [CW-1:0] wr_chara;
  logic [SW-1:0] wr_next_state;
  logic [AW:0]   entry_count;
  logic [SW-1:0] state_count;
  logic          err;
`ifdef TABLE_WRITER_OUTPUT_EN
  logic          out_wr_en;
  logic [SW-1:0] out_wr_state;
  logic [SW-1:0] out_wr_id;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct { int cur; int chara; int nxt; } ent_t;
  ent_t ents[$];
  int   m_cur, m_states, m_kw;
  bit   m_err, m_drop;
  int   kw_q[$];

  always #5 clk = ~clk;

  table_writer #(.DEPTH(DEPTH), .AW(AW), .SW(SW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .char_valid(char_valid), .char_ready(char_ready), .char(char_in), .char_last(char_last),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_cur_state(wr_cur_state), .wr_chara(wr_chara),
    .wr_next_state(wr_next_state), .entry_count(entry_count), .state_count(state_count), .err(err)
`ifdef TABLE_WRITER_OUTPUT_EN
    , .out_wr_en(out_wr_en), .out_wr_state(out_wr_state), .out_wr_id(out_wr_id)
`endif
  );

  task automatic model_reset();
    ents.delete();
    m_cur = 0; m_states = 0; m_kw = 0; m_err = 0; m_drop = 0;
  endtask

  task automatic send_char(input int c, input bit l);
    int k, n, nxt, exp_rdy, exp_wcyc, cyc, wr_seen, wr_cyc, guard;
    bit exp_write, overflow, rdy_seen, exp_pulse;
    int a_addr, a_cur, a_ch, a_next, p_seen, p_state, p_id;
    n = ents.size(); k = -1; nxt = 0; exp_write = 0; overflow = 0; exp_wcyc = -1;
    if (m_drop) exp_rdy = 1;
    else begin
      for (int i = 0; i < n; i++)
        if (k < 0 && ents[i].cur == m_cur && ents[i].chara == c) k = i;
      if (k >= 0) begin exp_rdy = k + 2; nxt = ents[k].nxt; end
      else if (n < DEPTH && m_states < (1 << SW) - 1) begin
        exp_write = 1; exp_wcyc = n + 2; exp_rdy = n + 3; nxt = m_states + 1;
      end else begin overflow = 1; exp_rdy = n + 2; end
    end
    exp_pulse = !m_drop && !overflow && l;

    guard = 0;
    @(negedge clk);
    while (char_ready !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
    checks++;
    if (char_ready !== 1'b1) begin errors++; $display("FAIL ready_wait: char_ready=%b required 1", char_ready); end
    char_valid = 1'b1; char_in = CW'(c); char_last = l;
    @(posedge clk); #1;
    char_valid = 1'b0;
    cyc = 1; rdy_seen = 0; wr_seen = 0; wr_cyc = -1; p_seen = 0;
    a_addr = 0; a_cur = 0; a_ch = 0; a_next = 0; p_state = 0; p_id = 0;
    while (!rdy_seen && cyc <= DEPTH + 10) begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        wr_seen++; wr_cyc = cyc;
        a_addr = int'(wr_addr); a_cur = int'(wr_cur_state); a_ch = int'(wr_chara); a_next = int'(wr_next_state);
      end
`ifdef TABLE_WRITER_OUTPUT_EN
      if (out_wr_en === 1'b1) begin p_seen++; p_state = int'(out_wr_state); p_id = int'(out_wr_id); end
`endif
      if (char_ready === 1'b1) rdy_seen = 1; else cyc++;
    end

    checks++;
    if (!rdy_seen || cyc != exp_rdy) begin
      errors++; $display("FAIL ready_cycle char=%0d: got cycle %0d (seen=%0b) required %0d", c, cyc, rdy_seen, exp_rdy);
    end
    checks++;
    if (wr_seen != int'(exp_write)) begin
      errors++; $display("FAIL wr_en_count char=%0d: got %0d required %0d", c, wr_seen, int'(exp_write));
    end
    if (exp_write && wr_seen == 1) begin
      checks++;
      if (wr_cyc != exp_wcyc || a_addr != n || a_cur != m_cur || a_ch != c || a_next != nxt) begin
        errors++;
        $display("FAIL wr_entry: got cyc%0d (%0d:%0d,%0d,%0d) required cyc%0d (%0d:%0d,%0d,%0d)",
                 wr_cyc, a_addr, a_cur, a_ch, a_next, exp_wcyc, n, m_cur, c, nxt);
      end
    end
`ifdef TABLE_WRITER_OUTPUT_EN
    checks++;
    if (p_seen != int'(exp_pulse) || (exp_pulse && (p_state != nxt || p_id != m_kw))) begin
      errors++;
      $display("FAIL out_pulse: got n=%0d state=%0d id=%0d required n=%0d state=%0d id=%0d",
               p_seen, p_state, p_id, int'(exp_pulse), nxt, m_kw);
    end
`endif

    if (m_drop) begin
      if (l) begin m_drop = 0; m_cur = 0; end
    end else if (overflow) begin
      m_err = 1;
      if (l) m_cur = 0; else m_drop = 1;
    end else begin
      if (exp_write) begin ents.push_back('{m_cur, c, nxt}); m_states = nxt; end
      m_cur = l ? 0 : nxt;
    end
    if (exp_pulse) m_kw++;
  endtask

  task automatic send_kw();
    for (int i = 0; i < kw_q.size(); i++) send_char(kw_q[i], i == kw_q.size() - 1);
    checks++;
    if (int'(entry_count) != ents.size() || int'(state_count) != m_states || err !== m_err) begin
      errors++;
      $display("FAIL counts: got entries=%0d states=%0d err=%b required %0d %0d %b",
               entry_count, state_count, err, ents.size(), m_states, m_err);
    end
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (char_ready !== 1'b1 || entry_count !== '0 || state_count !== '0 || err !== 1'b0) begin
      errors++;
      $display("FAIL clear_state: got ready=%b entries=%0d states=%0d err=%b required 1 0 0 0",
               char_ready, entry_count, state_count, err);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (char_ready !== 1'b0 || wr_en !== 1'b0 || wr_addr !== '0 || wr_cur_state !== '0 || wr_chara !== '0 ||
        wr_next_state !== '0 || entry_count !== '0 || state_count !== '0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s: got rdy=%b wr=%b addr=%0d cur=%0d ch=%0d nxt=%0d ent=%0d st=%0d err=%b required all 0",
               name, char_ready, wr_en, wr_addr, wr_cur_state, wr_chara, wr_next_state, entry_count, state_count, err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (char_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", char_ready); end
  endtask

  task automatic test_basic();
    kw_q = '{1, 2, 3};
    send_kw();
    checks++;
    if (entry_count !== 6'd3 || state_count !== 8'd3) begin
      errors++; $display("FAIL basic_counts: got %0d/%0d required 3/3", entry_count, state_count);
    end
    kw_q = '{1, 2, 5};
    send_kw();
    checks++;
    if (entry_count !== 6'd4 || state_count !== 8'd4) begin
      errors++; $display("FAIL shared_prefix_counts: got %0d/%0d required 4/4", entry_count, state_count);
    end
  endtask

  task automatic test_single();
    do_clear();
    kw_q = '{7};
    send_kw();
  endtask

  task automatic test_overflow();
    do_clear();
    kw_q.delete();
    for (int i = 0; i < DEPTH; i++) kw_q.push_back(1);
    send_kw();
    kw_q = '{9, 9};
    send_kw();
    checks++;
    if (err !== 1'b1 || entry_count !== 6'd32) begin
      errors++; $display("FAIL overflow_err: got err=%b entries=%0d required 1 32", err, entry_count);
    end
    kw_q = '{1, 1};
    send_kw();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b required 1", err); end
    do_clear();
  endtask

  task automatic test_clear_abort();
    do_clear();
    kw_q = '{1, 2};
    send_kw();
    @(negedge clk);
    char_valid = 1'b1; char_in = 4'd4; char_last = 1'b1;
    @(posedge clk); #1;
    char_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (wr_en !== 1'b1) begin errors++; $display("FAIL append_strobe: got %b required 1", wr_en); end
    clear = 1'b1;
    #1;
    checks++;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL clear_gates_wr: got %b required 0", wr_en); end
    @(posedge clk); #1;
    clear = 1'b0;
    model_reset();
    checks++;
    if (entry_count !== '0 || state_count !== '0 || wr_en !== 1'b0) begin
      errors++; $display("FAIL clear_abort: got ent=%0d st=%0d wr=%b required 0 0 0", entry_count, state_count, wr_en);
    end
    @(posedge clk); #1;
    checks++;
    if (char_ready !== 1'b1) begin errors++; $display("FAIL clear_ready: got %b required 1", char_ready); end

    kw_q = '{1, 2, 3};
    send_kw();
    @(negedge clk);
    char_valid = 1'b1; char_in = 4'd5; char_last = 1'b0;
    @(posedge clk); #1;
    char_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset_search");
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (char_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b required 1", char_ready); end
  endtask

  task automatic test_output();
    do_clear();
    kw_q = '{1, 2};
    send_kw();
    kw_q = '{3};
    send_kw();
  endtask

  task automatic test_random();
    int len;
    do_clear();
    for (int w = 0; w < 24; w++) begin
      len = $urandom_range(1, 4);
      kw_q.delete();
      for (int i = 0; i < len; i++) kw_q.push_back($urandom_range(0, 3));
      send_kw();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_overflow();
    test_clear_abort();
`ifdef TABLE_WRITER_OUTPUT_EN
    test_output();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
